// File: rtl/irq_controller.sv
// Edge-triggered, maskable interrupt controller with fixed lowest-index priority,
// INT/INTA request-acknowledge handshake and a single in-service slot released by EOI.
module irq_controller #(
  parameter int          N_SRC     = 8,
  parameter int          ID_W      = $clog2(N_SRC),
  parameter logic [31:0] VEC_BASE  = 32'h0000_0080,
  parameter int          VEC_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             inta_irq,
  input  logic             eoi,
  output logic             int_irq,
  output logic [31:0]      int_vec,
  output logic [ID_W-1:0]  int_id,
  output logic             in_service,
  output logic [N_SRC-1:0] pending
);

  // Handshake: int_irq is the request; the CPU acknowledges with a rising edge on
  // inta_irq while a request is outstanding, and later releases the slot with a
  // single-cycle eoi. Level on inta_irq carries no meaning, only its rising edge.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [N_SRC-1:0] src_d;
  logic             inta_d;
  logic [N_SRC-1:0] mask;

  logic [N_SRC-1:0] ev;
  logic             ack;
  logic [N_SRC-1:0] req;
  logic             any_req;
  logic [ID_W-1:0]  sel_id;
  logic [31:0]      sel_vec;
  logic             ack_take;
  logic [N_SRC-1:0] clr_vec;

  logic             int_irq_nx;
  logic [31:0]      int_vec_nx;
  logic [ID_W-1:0]  int_id_nx;
  logic             in_service_nx;

  assign ev       = src_irq & ~src_d;
  assign ack      = inta_irq & ~inta_d;
  assign req      = pending & ~mask;
  assign any_req  = |req;
  assign sel_vec  = VEC_BASE + (32'(sel_id) << VEC_SHIFT);
  assign ack_take = (state == REQ) && any_req && ack;

  // Descending scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    sel_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) sel_id = ID_W'(i);
    end
  end

  always_comb begin
    clr_vec = '0;
    if (ack_take) clr_vec[sel_id] = 1'b1;
  end

  // Edge history, mask and pending; a new event beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_d   <= '0;
      inta_d  <= 1'b0;
      mask    <= '0;
      pending <= '0;
    end else begin
      src_d   <= src_irq;
      inta_d  <= inta_irq;
      if (mask_we) mask <= mask_wdata;
      pending <= (pending & ~clr_vec) | ev;
    end
  end

  // State register together with the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      int_irq    <= 1'b0;
      int_vec    <= '0;
      int_id     <= '0;
      in_service <= 1'b0;
    end else begin
      state      <= state_nx;
      int_irq    <= int_irq_nx;
      int_vec    <= int_vec_nx;
      int_id     <= int_id_nx;
      in_service <= in_service_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = REQ;
      REQ: begin
        if (!any_req) state_nx = IDLE;
        else if (ack) state_nx = SERVICE;
      end
      SERVICE: if (eoi) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; int_vec/int_id keep their last value
  // after EOI so software can still read which handler ran.
  always_comb begin
    int_irq_nx    = int_irq;
    int_vec_nx    = int_vec;
    int_id_nx     = int_id;
    in_service_nx = in_service;
    case (state)
      IDLE: begin
        if (any_req) begin
          int_irq_nx = 1'b1;
          int_id_nx  = sel_id;
        end
      end
      REQ: begin
        if (!any_req) begin
          int_irq_nx = 1'b0;
        end else if (ack) begin
          int_irq_nx    = 1'b0;
          in_service_nx = 1'b1;
          int_id_nx     = sel_id;
          int_vec_nx    = sel_vec;
        end else begin
          int_id_nx = sel_id;
        end
      end
      SERVICE: begin
        if (eoi) in_service_nx = 1'b0;
      end
      default: begin
        int_irq_nx    = 1'b0;
        in_service_nx = 1'b0;
      end
    endcase
  end

endmodule
